// File: rtl/fetch_unit.sv
// Sequential Y86-64 fetch stage: owns the PC, reads instruction bytes one at a time and decodes them.
// Latency: first imem_req one cycle after reset release or pc_load; instr_valid one cycle after the last ack.
// Backpressure: holds each imem_addr until imem_ack; holds all decoded outputs in DONE until pc_load (AOK only).
// Ports: Clk/Rst_n (sync active-low); imem_req/imem_addr/imem_rdata/imem_ack byte-read handshake;
//        instr_valid, PC, icode, ifun, rA, rB, valC, valP, stat decoded instruction; pc_load/pc_next from PC update.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [63:0] PC,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  input  logic        pc_load,
  input  logic [63:0] pc_next
);

  localparam logic [63:0] MEM_LIMIT = 64'(IMEM_SIZE);
  localparam logic [2:0]  ST_AOK = 3'd1;
  localparam logic [2:0]  ST_HLT = 3'd2;
  localparam logic [2:0]  ST_ADR = 3'd3;
  localparam logic [2:0]  ST_INS = 3'd4;

  typedef enum logic {S_FETCH = 1'b0, S_DONE = 1'b1} state_t;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  function automatic logic instr_ok(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7:                                      instr_ok = (fn <= 4'd6);
      4'h6:                                            instr_ok = (fn <= 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: instr_ok = (fn == 4'd0);
      default:                                         instr_ok = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  idx_q, idx_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic [2:0]  stat_q, stat_d;

  logic [63:0] byte_addr, next_addr;
  logic [3:0]  cur_icode, cur_len;
  logic [2:0]  vc_idx;

  assign byte_addr = pc_q + {60'd0, idx_q};
  assign next_addr = byte_addr + 64'd1;
  // On byte 0 the icode register is not loaded yet, so decode straight from the bus.
  assign cur_icode = (idx_q == 4'd0) ? imem_rdata[7:4] : icode_q;
  assign cur_len   = instr_len(cur_icode);
  // valC byte lane: constant starts after the register byte when one is present (mod-8 wrap is intended).
  assign vc_idx    = idx_q[2:0] - (has_regs(icode_q) ? 3'd2 : 3'd1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    req_d   = req_q;
    valid_d = valid_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    stat_d  = stat_q;
    if (state_q == S_FETCH) begin
      if (!req_q) begin
        // Idle in FETCH only right after reset or after a load to an unreachable PC.
        if (byte_addr < MEM_LIMIT) begin
          req_d = 1'b1;
        end else begin
          state_d = S_DONE;
          valid_d = 1'b1;
          stat_d  = ST_ADR;
          valp_d  = byte_addr;
        end
      end else if (imem_ack) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd0) begin
          icode_d = imem_rdata[7:4];
          ifun_d  = imem_rdata[3:0];
        end else if (idx_q == 4'd1 && has_regs(icode_q)) begin
          ra_d = imem_rdata[7:4];
          rb_d = imem_rdata[3:0];
        end else begin
          valc_d[{vc_idx, 3'b000} +: 8] = imem_rdata;
        end
        if (idx_q == 4'd0 && !instr_ok(imem_rdata[7:4], imem_rdata[3:0])) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          valid_d = 1'b1;
          stat_d  = ST_INS;
          valp_d  = pc_q + 64'd1;
        end else if (idx_q + 4'd1 == cur_len) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          valid_d = 1'b1;
          stat_d  = (cur_icode == 4'h0) ? ST_HLT : ST_AOK;
          valp_d  = pc_q + {60'd0, cur_len};
        end else if (next_addr >= MEM_LIMIT) begin
          // Next byte is out of memory: stop without requesting it; valP reports that address.
          req_d   = 1'b0;
          state_d = S_DONE;
          valid_d = 1'b1;
          stat_d  = ST_ADR;
          valp_d  = next_addr;
        end
      end
    end else if (pc_load && stat_q == ST_AOK) begin
      state_d = S_FETCH;
      valid_d = 1'b0;
      pc_d    = pc_next;
      idx_d   = 4'd0;
      req_d   = (pc_next < MEM_LIMIT);
      icode_d = 4'h0;
      ifun_d  = 4'h0;
      ra_d    = 4'hF;
      rb_d    = 4'hF;
      valc_d  = 64'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      idx_q   <= 4'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= 64'd0;
      valp_q  <= RESET_PC;
      stat_q  <= ST_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = byte_addr;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign stat        = stat_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: byte memory responder with programmable ack delay, scoreboard of expected instructions.
// Latency: checks instr_valid arrives exactly one cycle after the last ack.
// Backpressure: responder stretches acks to exercise address stability and late-ack-after-reset handling.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n, imem_req, imem_ack, instr_valid, pc_load;
  logic [63:0] imem_addr, PC, valC, valP, pc_next;
  logic [7:0]  imem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;

  always #5 Clk = ~Clk;

  fetch_unit #(.RESET_PC(64'h0), .IMEM_SIZE(1024)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .PC(PC), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat), .pc_load(pc_load), .pc_next(pc_next)
  );

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    logic [2:0]  stat;
    bit          chk_valp;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [0:1023];
  int          checks = 0, errors = 0;
  int          cyc = 0, last_ack_cyc = 0, acks = 0, req_cycles = 0;
  int          bad_addr_req = 0, addr_unstable = 0, ack_delay = 0;
  bit          inject_ack = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                          input logic [63:0] pc, input logic [2:0] st, input bit cv);
    exp_t e;
    e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
    e.valc = vc; e.valp = vp; e.pc = pc; e.stat = st; e.chk_valp = cv;
    exp_q.push_back(e);
  endtask

  task automatic expect_instr(input int maxc);
    int   n = 0;
    exp_t e;
    while (instr_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    check("valid_seen", instr_valid, 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=valid expected=queued_entry");
      return;
    end
    e = exp_q.pop_front();
    check("latency", cyc, last_ack_cyc + 1);
    check("pc", PC, e.pc);
    check("icode", icode, e.icode);
    check("ifun", ifun, e.ifun);
    check("rA", rA, e.ra);
    check("rB", rB, e.rb);
    check("valC", valC, e.valc);
    check("stat", stat, e.stat);
    if (e.chk_valp) check("valP", valP, e.valp);
  endtask

  task automatic load_pc(input logic [63:0] a);
    pc_load = 1'b1;
    pc_next = a;
    tick();
    pc_load = 1'b0;
    check("req_after_load", imem_req, 1);
    check("addr_after_load", imem_addr, a);
    check("valid_drops", instr_valid, 0);
  endtask

  task automatic load_irmovq(input int base);
    logic [79:0] b = 80'h30F3EFCDAB8967452301;
    for (int i = 0; i < 10; i++) mem[base + i] = b[79 - 8*i -: 8];
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_pc"}, PC, 64'h0);
    check({tag, "_icode"}, icode, 0);
    check({tag, "_ifun"}, ifun, 0);
    check({tag, "_rA"}, rA, 4'hF);
    check({tag, "_rB"}, rB, 4'hF);
    check({tag, "_valC"}, valC, 0);
    check({tag, "_valP"}, valP, 64'h0);
    check({tag, "_stat"}, stat, 1);
  endtask

  // Byte memory: acks after ack_delay waiting cycles; inject_ack forces a stray ack with junk data.
  initial begin : responder
    int          wait_cnt;
    bit          waiting;
    logic [63:0] wait_addr;
    wait_cnt = 0; waiting = 1'b0; wait_addr = '0;
    imem_ack = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge Clk);
      if (inject_ack) begin
        imem_ack = 1'b1; imem_rdata = 8'hFF; wait_cnt = 0; waiting = 1'b0;
      end else if (imem_req === 1'b1) begin
        req_cycles++;
        if (imem_addr >= 64'd1024) bad_addr_req++;
        if (waiting && imem_addr !== wait_addr) addr_unstable++;
        if (wait_cnt >= ack_delay) begin
          imem_ack = 1'b1; imem_rdata = mem[imem_addr[9:0]];
          wait_cnt = 0; waiting = 1'b0; last_ack_cyc = cyc; acks++;
        end else begin
          imem_ack = 1'b0; wait_cnt++; waiting = 1'b1; wait_addr = imem_addr;
        end
      end else begin
        imem_ack = 1'b0; wait_cnt = 0; waiting = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    int rc, a0, n;
    Rst_n = 1'b0; pc_load = 1'b0; pc_next = 64'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    tick(); tick();
    check_reset_vals("reset");

    // nop at 0 with same-cycle ack, then nop at 1
    mem[0] = 8'h10; mem[1] = 8'h10; ack_delay = 0;
    push_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h0, 3'd1, 1'b1);
    Rst_n = 1'b1;
    tick();
    check("req_after_reset", imem_req, 1);
    check("addr_after_reset", imem_addr, 64'h0);
    expect_instr(20);
    push_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2, 64'h1, 3'd1, 1'b1);
    load_pc(64'h1);
    expect_instr(20);

    // irmovq at 0x20 with 2 wait cycles per byte
    load_irmovq(32'h20); ack_delay = 2;
    push_exp(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h2A, 64'h20, 3'd1, 1'b1);
    load_pc(64'h20);
    expect_instr(100);
    check("addr_stable", addr_unstable, 0);

    // OPq, call, ret, cmovXX back to back with one wait cycle
    mem[32'h40] = 8'h61; mem[32'h41] = 8'h12;
    mem[32'h42] = 8'h80;
    for (int i = 0; i < 8; i++) mem[32'h43 + i] = 8'(8'h11 * (i + 1));
    mem[32'h4B] = 8'h90;
    mem[32'h4C] = 8'h26; mem[32'h4D] = 8'h34;
    ack_delay = 1;
    push_exp(4'h6, 4'h1, 4'h1, 4'h2, 64'h0, 64'h42, 64'h40, 3'd1, 1'b1);
    load_pc(64'h40);
    expect_instr(50);
    push_exp(4'h8, 4'h0, 4'hF, 4'hF, 64'h8877665544332211, 64'h4B, 64'h42, 3'd1, 1'b1);
    load_pc(64'h42);
    expect_instr(50);
    push_exp(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h4C, 64'h4B, 3'd1, 1'b1);
    load_pc(64'h4B);
    expect_instr(50);
    push_exp(4'h2, 4'h6, 4'h3, 4'h4, 64'h0, 64'h4E, 64'h4C, 3'd1, 1'b1);
    load_pc(64'h4C);
    expect_instr(50);

    // jXX running off the end of memory
    mem[1020] = 8'h70; mem[1021] = 8'hAA; mem[1022] = 8'hBB; mem[1023] = 8'hCC;
    push_exp(4'h7, 4'h0, 4'hF, 4'hF, 64'hCCBBAA, 64'h0, 64'd1020, 3'd3, 1'b0);
    load_pc(64'd1020);
    expect_instr(50);
    rc = req_cycles;
    pc_load = 1'b1; pc_next = 64'h0;
    tick(); tick(); tick();
    pc_load = 1'b0;
    check("adr_no_req_1024", bad_addr_req, 0);
    check("adr_hold_valid", instr_valid, 1);
    check("adr_hold_pc", PC, 64'd1020);
    check("adr_no_new_req", req_cycles, rc);

    // invalid icode
    Rst_n = 1'b0; tick();
    mem[0] = 8'hC0; ack_delay = 0;
    push_exp(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h0, 3'd4, 1'b1);
    Rst_n = 1'b1;
    expect_instr(20);
    rc = req_cycles;
    pc_load = 1'b1; pc_next = 64'h40;
    tick(); tick(); tick(); tick();
    pc_load = 1'b0;
    check("ins_hold_valid", instr_valid, 1);
    check("ins_hold_pc", PC, 64'h0);
    check("ins_hold_stat", stat, 4);
    check("ins_no_new_req", req_cycles, rc);

    // OPq with out-of-range ifun
    Rst_n = 1'b0; tick();
    mem[0] = 8'h64;
    push_exp(4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'h1, 64'h0, 3'd4, 1'b1);
    Rst_n = 1'b1;
    expect_instr(20);

    // halt, pc_load ignored, reset restarts
    Rst_n = 1'b0; tick();
    mem[0] = 8'h00;
    push_exp(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h0, 3'd2, 1'b1);
    Rst_n = 1'b1;
    expect_instr(20);
    pc_load = 1'b1; pc_next = 64'h40;
    tick(); tick();
    pc_load = 1'b0;
    check("hlt_hold_pc", PC, 64'h0);
    check("hlt_hold_valid", instr_valid, 1);
    check("hlt_hold_stat", stat, 2);
    Rst_n = 1'b0; tick();
    check_reset_vals("hlt_reset");
    push_exp(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h0, 3'd2, 1'b1);
    Rst_n = 1'b1;
    tick();
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 64'h0);
    expect_instr(20);

    // reset in the middle of a slow irmovq, with a stray ack during and after reset
    Rst_n = 1'b0; tick();
    load_irmovq(0); ack_delay = 3;
    push_exp(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'hA, 64'h0, 3'd1, 1'b1);
    a0 = acks;
    Rst_n = 1'b1;
    n = 0;
    while (acks < a0 + 4 && n < 200) begin
      tick();
      n++;
    end
    check("abort_setup_acks", (acks >= a0 + 4), 1);
    tick();
    Rst_n = 1'b0; inject_ack = 1'b1;
    tick();
    check_reset_vals("abort");
    Rst_n = 1'b1;
    tick();
    inject_ack = 1'b0;
    check("abort_restart_req", imem_req, 1);
    check("abort_restart_addr", imem_addr, 64'h0);
    expect_instr(200);
    check("abort_addr_stable", addr_unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequential fetch stage for the SEQ Y86-64 core. Owns the architectural PC register.
- Reads instruction bytes one at a time from a byte-wide instruction memory using a req/ack handshake.
- Decodes the fields icode, ifun, rA, rB, valC and valP, plus a status code, then presents the assembled instruction downstream.
- Loads the next PC from the PC-update stage on a strobe, then starts the next fetch.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_SIZE, 1024, instruction memory size in bytes. Any byte address >= IMEM_SIZE is an address error.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  byte read request.
- imem_addr  out  64  byte address. Stable while imem_req=1 and ack not yet seen.
- imem_rdata  in  8  read byte. Valid when imem_ack=1.
- imem_ack  in  1  read complete. May assert in the same cycle as req (combinational memory) or any later cycle.
- instr_valid  out  1  decoded instruction and status outputs are valid.
- PC  out  64  address of the current instruction.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register A; 4'hF when absent.
- rB  out  4  register B; 4'hF when absent.
- valC  out  64  constant, little-endian assembled; 0 when absent.
- valP  out  64  PC + instruction length.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- pc_load  in  1  downstream strobe: accept the instruction and load pc_next.
- pc_next  in  64  next PC from the PC-update stage.

Behaviour:
- Reset (Rst_n=0 at an edge):
  - PC=RESET_PC, state=FETCH, byte counter=0.
  - imem_req=0, instr_valid=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=RESET_PC, stat=1.
  - Applies mid-fetch too: the outstanding request is abandoned, and any ack arriving in or after the reset cycle is ignored.
- States: FETCH, DONE.
- FETCH:
  - imem_addr = PC + byte index; imem_req=1.
  - On each cycle with imem_ack=1, capture imem_rdata into byte[index] and increment the index. The next byte is requested in the following cycle.
  - Throughput with zero-wait memory: 1 byte per cycle.
- Byte 0 splits into icode = bits[7:4] and ifun = bits[3:0].
- Instruction lengths by icode:
  - 0 halt: 1
  - 1 nop: 1
  - 2 cmovXX: 2
  - 3 irmovq: 10
  - 4 rmmovq: 10
  - 5 mrmovq: 10
  - 6 OPq: 2
  - 7 jXX: 9
  - 8 call: 9
  - 9 ret: 1
  - A pushq: 2
  - B popq: 2
- Register byte: present for icode 2,3,4,5,6,A,B; rA = bits[7:4], rB = bits[3:0].
- valC location: bytes 2..9 for icode 3,4,5; bytes 1..8 for icode 7,8. Least-significant byte first.
- Instruction check (INS) after byte 0:
  - icode > 4'hB is invalid.
  - ifun > 6 is invalid for icode 2 or 7.
  - ifun > 3 is invalid for icode 6.
  - ifun != 0 is invalid for any other icode.
  - On INS: stop fetching, go to DONE with stat=4 and valP=PC+1.
- Address check (ADR): if the next byte address >= IMEM_SIZE, issue no request, go to DONE with stat=3. Already-captured fields are held; unfetched fields read 0/F.
- Completion: after the last byte, go to DONE; valP = PC + length, mod 2^64 wrap. stat=2 if icode=0, else 1.
- DONE:
  - instr_valid=1, imem_req=0; all outputs held stable.
  - If stat=AOK and pc_load=1: PC <= pc_next, index <= 0, state <= FETCH, instr_valid=0 from the next cycle.
  - pc_load is ignored in FETCH, and ignored in DONE when stat != AOK. The unit stays in DONE until reset.
- Simultaneous events: Rst_n=0 has priority over pc_load and imem_ack.
- Fetch latency: first imem_req in the cycle after reset or pc_load; instr_valid in the cycle after the last ack.

Test Plan:
- Reset, then nop (0x10) at addr 0 with same-cycle ack -> icode=1, ifun=0, rA=rB=F, valP=1, stat=1, instr_valid exactly 1 cycle after the ack; pc_load with pc_next=1 -> next fetch at addr 1.
- irmovq bytes 30 F3 EF CD AB 89 67 45 23 01 at addr 0x20, ack delayed 2 cycles per byte -> rA=F, rB=3, valC=64'h0123456789ABCDEF, valP=0x2A; imem_addr stable across each wait.
- Fetch 0xC0 at 0 -> stat=4, valP=1, instr_valid held high; pc_load ignored; no further imem_req.
- With IMEM_SIZE=1024, jXX (0x70) at 1020 -> bytes 1020..1023 fetched, no request at 1024, stat=3.
- halt (0x00) -> stat=2, pc_load ignored; then Rst_n=0 -> PC=RESET_PC, fetch restarts.
- Assert Rst_n=0 midway through a 10-byte fetch with a late ack -> all outputs return to reset values, the late ack is ignored, and the fetch restarts at RESET_PC.
